// File: rtl/systolic_collector_if.sv
// Handshake bundle between the systolic array bottom row, the collector and its consumer.
interface systolic_collector_if #(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int SUM_WIDTH      = 16,
  parameter int OUT_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 8
);
  logic                                in_valid;
  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] sum_in;
  logic                                flush;
  logic                                out_valid;
  logic                                out_ready;
  logic [SYSTOLIC_WIDTH*OUT_WIDTH-1:0] out_data;
  logic [$clog2(FIFO_DEPTH):0]         count;
  logic                                overflow;

  modport master (
    output in_valid, sum_in, flush, out_ready,
    input  out_valid, out_data, count, overflow
  );

  modport slave (
    input  in_valid, sum_in, flush, out_ready,
    output out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/systolic_collector.sv
// Deskews column-skewed systolic sums into row vectors, narrows each lane and queues rows in a FIFO.
// Define SYSTOLIC_COLLECT_SAT_EN to saturate lanes instead of truncating them.
module systolic_collector #(
  parameter int SYSTOLIC_WIDTH = 4,
  parameter int SUM_WIDTH      = 16,
  parameter int OUT_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 8
) (
  input logic               clk,
  input logic               rst_n,
  systolic_collector_if.slave bus
);
  localparam int W  = SYSTOLIC_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

`ifdef SYSTOLIC_COLLECT_SAT_EN
  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  function automatic logic [OUT_WIDTH-1:0] narrow(input logic [SUM_WIDTH-1:0] value);
    logic signed [SUM_WIDTH-1:0] sval;
    sval = $signed(value);
    if (sval > SAT_MAX)
      return SAT_MAX[OUT_WIDTH-1:0];
    else if (sval < SAT_MIN)
      return SAT_MIN[OUT_WIDTH-1:0];
    else
      return value[OUT_WIDTH-1:0];
  endfunction
`endif

  logic [W-1:0][OUT_WIDTH-1:0] aligned;
  logic [W-2:0]                valid_pipe;
  logic                        aligned_valid;
  logic [W*OUT_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count_q;
  logic                        overflow_q;
  logic                        has_data;
  logic                        full;
  logic                        pop;
  logic                        push;

  // Lanes are narrowed on entry so the deskew registers only carry OUT_WIDTH bits.
  for (genvar j = 0; j < W; j++) begin : g_lane
    localparam int LAG = W - 1 - j;
    logic [SUM_WIDTH-1:0] lane_sum;
    logic [OUT_WIDTH-1:0] lane_narrow;

    assign lane_sum = bus.sum_in[j*SUM_WIDTH +: SUM_WIDTH];

`ifdef SYSTOLIC_COLLECT_SAT_EN
    assign lane_narrow = narrow(lane_sum);
`else
    if (SUM_WIDTH > OUT_WIDTH) begin : g_drop
      logic unused_upper;
      assign unused_upper = ^lane_sum[SUM_WIDTH-1:OUT_WIDTH];
    end
    assign lane_narrow = lane_sum[OUT_WIDTH-1:0];
`endif

    if (LAG == 0) begin : g_pass
      assign aligned[j] = lane_narrow;
    end else begin : g_delay
      logic [OUT_WIDTH-1:0] stage [LAG];
      always_ff @(posedge clk) begin
        stage[0] <= lane_narrow;
        for (int k = 1; k < LAG; k++)
          stage[k] <= stage[k-1];
      end
      assign aligned[j] = stage[LAG-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid_pipe <= '0;
    else if (bus.flush)
      valid_pipe <= '0;
    else
      valid_pipe <= (valid_pipe << 1) | (W-1)'(bus.in_valid);
  end

  assign aligned_valid = valid_pipe[W-2];
  assign has_data      = (count_q != '0);
  assign full          = (count_q == FULL_COUNT);
  assign pop           = has_data && bus.out_ready;
  assign push          = aligned_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push && !bus.flush)
      mem[wr_ptr] <= aligned;
  end

  // A full FIFO with a coincident pop still accepts the row; only a true overrun sets the sticky flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (aligned_valid && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  assign bus.out_valid = has_data;
  assign bus.out_data  = has_data ? mem[rd_ptr] : '0;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_systolic_collector.sv
// Self-checking bench for systolic_collector: table vectors, corner sequences and a randomized queue model.
module tb_systolic_collector;
  localparam int W     = 4;
  localparam int SW    = 16;
  localparam int OW    = 8;
  localparam int DEPTH = 8;
  localparam int HI    = (1 << (OW-1)) - 1;
  localparam int LO    = -(1 << (OW-1));

  typedef struct {
    string              name;
    logic [W*SW-1:0]    row;
    logic [W*OW-1:0]    expect_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_collector_if #(.SYSTOLIC_WIDTH(W), .SUM_WIDTH(SW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) bus ();

  systolic_collector #(.SYSTOLIC_WIDTH(W), .SUM_WIDTH(SW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              tests_run = 0;
  int              tests_failed = 0;
  int              cyc = 0;
  int              kill_cycle = -100;
  bit              ring_valid [8];
  logic [W*SW-1:0] ring_row [8];
  logic [W*OW-1:0] model_q [$];
  bit              model_ovf = 1'b0;
  vec_t            tbl [5];
  logic [W*SW-1:0] rnd_row;

  function automatic logic [W*SW-1:0] rowOf(input int a, input int b, input int c, input int d);
    return {SW'(d), SW'(c), SW'(b), SW'(a)};
  endfunction

  // Narrowing from the lane's integer value: clamp to the signed output range or wrap modulo 2^OW.
  function automatic logic [W*OW-1:0] narrowRow(input logic [W*SW-1:0] row);
    logic [W*OW-1:0] r;
    int v;
    r = '0;
    for (int j = 0; j < W; j++) begin
      v = int'($signed(row[j*SW +: SW]));
`ifdef SYSTOLIC_COLLECT_SAT_EN
      if (v > HI) v = HI;
      else if (v < LO) v = LO;
`endif
      r[j*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  task automatic compare(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [W*OW-1:0] head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    compare({tag, ".out_valid"}, 64'(bus.out_valid), 64'(model_q.size() != 0));
    compare({tag, ".out_data"},  64'(bus.out_data),  64'(head));
    compare({tag, ".count"},     64'(bus.count),     64'(model_q.size()));
    compare({tag, ".overflow"},  64'(bus.overflow),  64'(model_ovf));
  endtask

  // Drives one cycle: row lanes go out skewed, the queue model advances, then waits to the next negedge.
  task automatic applyStimulus(input bit issue, input logic [W*SW-1:0] row, input bit rdy, input bit fl);
    logic [W*SW-1:0] drive;
    int at;
    bit arrival;
    bit pop;
    bit full;
    ring_valid[cyc & 7] = issue;
    ring_row[cyc & 7]   = row;
    for (int j = 0; j < W; j++) begin
      if (ring_valid[(cyc - j) & 7])
        drive[j*SW +: SW] = ring_row[(cyc - j) & 7][j*SW +: SW];
      else
        drive[j*SW +: SW] = SW'($urandom);
    end
    bus.in_valid  = issue;
    bus.sum_in    = drive;
    bus.out_ready = rdy;
    bus.flush     = fl;
    if (!rst_n || fl) begin
      model_q.delete();
      model_ovf  = 1'b0;
      kill_cycle = cyc;
    end else begin
      at      = cyc - (W - 1);
      arrival = (at >= 0) && (at > kill_cycle) && ring_valid[at & 7];
      pop     = (model_q.size() != 0) && rdy;
      full    = (model_q.size() == DEPTH);
      if (pop)
        void'(model_q.pop_front());
      if (arrival) begin
        if (!full || pop)
          model_q.push_back(narrowRow(ring_row[at & 7]));
        else
          model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic stepCheck(input bit issue, input logic [W*SW-1:0] row, input bit rdy, input bit fl, input string tag);
    applyStimulus(issue, row, rdy, fl);
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input bit rdy, input string tag);
    for (int i = 0; i < n; i++)
      stepCheck(1'b0, '0, rdy, 1'b0, tag);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.sum_in    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    tbl[0] = '{"ramp",    rowOf(10, 11, 12, 13),        {8'h0D, 8'h0C, 8'h0B, 8'h0A}};
`ifdef SYSTOLIC_COLLECT_SAT_EN
    tbl[1] = '{"narrow",  rowOf(300, -200, 127, -128),  {8'h80, 8'h7F, 8'h80, 8'h7F}};
    tbl[2] = '{"edge",    rowOf(0, -1, 128, -129),      {8'h80, 8'h7F, 8'hFF, 8'h00}};
    tbl[3] = '{"extreme", rowOf(32767, -32768, 255, -256), {8'h80, 8'h7F, 8'h80, 8'h7F}};
`else
    tbl[1] = '{"narrow",  rowOf(300, -200, 127, -128),  {8'h80, 8'h7F, 8'h38, 8'h2C}};
    tbl[2] = '{"edge",    rowOf(0, -1, 128, -129),      {8'h7F, 8'h80, 8'hFF, 8'h00}};
    tbl[3] = '{"extreme", rowOf(32767, -32768, 255, -256), {8'h00, 8'hFF, 8'h00, 8'hFF}};
`endif
    tbl[4] = '{"inrange", rowOf(-5, 5, 100, -100),      {8'h9C, 8'h64, 8'h05, 8'hFB}};

    @(negedge clk);
    compare("reset.out_valid", 64'(bus.out_valid), 64'd0);
    compare("reset.out_data",  64'(bus.out_data),  64'd0);
    compare("reset.count",     64'(bus.count),     64'd0);
    compare("reset.overflow",  64'(bus.overflow),  64'd0);
    stepCheck(1'b0, '0, 1'b0, 1'b0, "reset_hold");
    stepCheck(1'b0, '0, 1'b0, 1'b0, "reset_hold");
    rst_n = 1'b1;
    idle(2, 1'b1, "post_reset");

    // Single rows: exact latency W, then the entry is consumed.
    for (int i = 0; i < 5; i++) begin
      stepCheck(1'b1, tbl[i].row, 1'b1, 1'b0, tbl[i].name);
      idle(W - 2, 1'b1, tbl[i].name);
      compare({tbl[i].name, ".early_valid"}, 64'(bus.out_valid), 64'd0);
      idle(1, 1'b1, tbl[i].name);
      compare({tbl[i].name, ".valid"}, 64'(bus.out_valid), 64'd1);
      compare({tbl[i].name, ".data"},  64'(bus.out_data),  64'(tbl[i].expect_data));
      idle(1, 1'b1, tbl[i].name);
      compare({tbl[i].name, ".gone"},  64'(bus.out_valid), 64'd0);
    end

    // Backpressure: ten rows into an eight-deep FIFO.
    stepCheck(1'b0, '0, 1'b0, 1'b1, "bp_flush");
    for (int k = 1; k <= 10; k++)
      stepCheck(1'b1, rowOf(k, k, k, k), 1'b0, 1'b0, "bp_fill");
    idle(W, 1'b0, "bp_settle");
    compare("bp.count",    64'(bus.count),    64'd8);
    compare("bp.overflow", 64'(bus.overflow), 64'd1);
    for (int k = 1; k <= DEPTH; k++) begin
      compare("bp.drain_data", 64'(bus.out_data), 64'({W{8'(k)}}));
      stepCheck(1'b0, '0, 1'b1, 1'b0, "bp_drain");
    end
    compare("bp.empty",       64'(bus.out_valid), 64'd0);
    compare("bp.sticky_ovf",  64'(bus.overflow),  64'd1);

    // Full FIFO with simultaneous push and pop at full rate.
    stepCheck(1'b0, '0, 1'b0, 1'b1, "full_flush");
    compare("flush.clears_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 30; i++) begin
      stepCheck(1'b1, rowOf(20 + i, 21 + i, 22 + i, 23 + i), i >= DEPTH + W - 1, 1'b0, "full_stream");
      if (i >= DEPTH + W - 2) begin
        compare("full.count",    64'(bus.count),    64'd8);
        compare("full.overflow", 64'(bus.overflow), 64'd0);
      end
    end
    idle(DEPTH + W + 2, 1'b1, "full_drain");

    // Flush with three rows buffered and two in flight, one arriving in the flush cycle.
    for (int i = 0; i < 3; i++)
      stepCheck(1'b1, rowOf(40 + i, 41, 42, 43), 1'b0, 1'b0, "fl_fill");
    idle(4, 1'b0, "fl_wait");
    compare("fl.buffered", 64'(bus.count), 64'd3);
    stepCheck(1'b1, rowOf(50, 51, 52, 53), 1'b0, 1'b0, "fl_inflight");
    stepCheck(1'b1, rowOf(60, 61, 62, 63), 1'b0, 1'b0, "fl_inflight");
    idle(2, 1'b0, "fl_inflight");
    stepCheck(1'b0, '0, 1'b1, 1'b1, "fl_pulse");
    compare("fl.count",     64'(bus.count),     64'd0);
    compare("fl.out_valid", 64'(bus.out_valid), 64'd0);
    compare("fl.overflow",  64'(bus.overflow),  64'd0);
    idle(W + 1, 1'b1, "fl_after");

    // Reset mid-operation with five rows buffered and one in flight.
    for (int i = 0; i < 5; i++)
      stepCheck(1'b1, rowOf(i, i + 1, i + 2, i + 3), 1'b0, 1'b0, "rst_fill");
    idle(W, 1'b0, "rst_settle");
    stepCheck(1'b1, rowOf(99, 98, 97, 96), 1'b0, 1'b0, "rst_inflight");
    rst_n = 1'b0;
    #1;
    compare("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    compare("midrst.out_data",  64'(bus.out_data),  64'd0);
    compare("midrst.count",     64'(bus.count),     64'd0);
    compare("midrst.overflow",  64'(bus.overflow),  64'd0);
    stepCheck(1'b0, '0, 1'b1, 1'b0, "midrst_hold");
    stepCheck(1'b0, '0, 1'b1, 1'b0, "midrst_hold");
    rst_n = 1'b1;
    stepCheck(1'b1, tbl[0].row, 1'b1, 1'b0, "rst_resume");
    idle(W - 2, 1'b1, "rst_resume");
    compare("resume.early_valid", 64'(bus.out_valid), 64'd0);
    idle(1, 1'b1, "rst_resume");
    compare("resume.valid", 64'(bus.out_valid), 64'd1);
    compare("resume.data",  64'(bus.out_data),  64'(tbl[0].expect_data));
    idle(2, 1'b1, "rst_resume");

    // Randomized traffic: sparse consumer first to provoke overflow, then a busy one.
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < W; j++)
        rnd_row[j*SW +: SW] = ($urandom_range(0, 1) == 1) ? SW'($urandom)
                                                          : SW'(int'($urandom_range(0, 255)) - 128);
      stepCheck(1'(($urandom_range(0, 1))), rnd_row,
                ($urandom_range(0, 99) < ((i < 200) ? 25 : 80)),
                ($urandom_range(0, 59) == 0), "random");
    end
    idle(DEPTH + W + 2, 1'b1, "random_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
